// File: rtl/hwpe_stream_package.sv
// Shared types and constants for the credit-based stream transmitter.
//   flags_credit_tx_t  : status bundle (credits, empty, stall, overflow)
//   credit_tx_state_e  : transmitter output-register state
package hwpe_stream_package;

  localparam int unsigned HWPE_STREAM_CREDIT_MAX = 255;

  typedef struct packed {
    logic [7:0] credits;
    logic       empty;
    logic       stall;
    logic       overflow;
  } flags_credit_tx_t;

  typedef enum logic [1:0] {
    StEmpty   = 2'b00,
    StHold    = 2'b01,
    StStalled = 2'b10
  } credit_tx_state_e;

endpackage

// File: rtl/hwpe_stream_intf_stream.sv
// HWPE-Stream interface: valid/ready handshake with data and byte strobes.
//   source : drives valid, data, strb; receives ready
//   sink   : receives valid, data, strb; drives ready
interface hwpe_stream_intf_stream #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8
);

  logic                  valid;
  logic                  ready;
  logic [DATA_WIDTH-1:0] data;
  logic [STRB_WIDTH-1:0] strb;

  modport source (output valid, output data, output strb, input ready);
  modport sink   (input valid, input data, input strb, output ready);

endinterface

// File: rtl/hwpe_stream_credit_counter.sv
// Saturating 8-bit credit counter, usable on either side of a credit link.
//   clk, rst_n : clock, async active-low reset
//   clear      : synchronous return to CREDITS, clears overflow
//   consume    : one credit used (must never fire with count == 0)
//   give       : one credit returned
//   count      : current credit count
//   nonzero    : count != 0
//   overflow   : sticky, a give arrived with the counter already full
module hwpe_stream_credit_counter
  import hwpe_stream_package::*;
#(
  parameter int unsigned CREDITS = 8  // 1 .. HWPE_STREAM_CREDIT_MAX
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       consume,
  input  logic       give,
  output logic [7:0] count,
  output logic       nonzero,
  output logic       overflow
);

  localparam logic [7:0] CreditsInit = 8'(CREDITS);

  logic [7:0] count_d, count_q;
  logic       ovf_d, ovf_q;

  always_comb begin
    count_d = count_q;
    ovf_d   = ovf_q;
    if (clear) begin
      count_d = CreditsInit;
      ovf_d   = 1'b0;
    end else if (consume && !give) begin
      count_d = count_q - 8'd1;
    end else if (give && !consume) begin
      // A full counter cannot accept another credit: saturate and flag it.
      if (count_q == CreditsInit) begin
        ovf_d = 1'b1;
      end else begin
        count_d = count_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= CreditsInit;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  assign count    = count_q;
  assign nonzero  = (count_q != 8'd0);
  assign overflow = ovf_q;

  no_underflow_a : assert property (@(posedge clk) disable iff (!rst_n)
    !(consume && (count_q == 8'd0)));

endmodule

// File: rtl/hwpe_stream_credit_tx.sv
// Credit-based stream transmitter with a single output register.
// Beats are forwarded to a remote FIFO only while credits remain; each pop
// handshake consumes a credit, each credit_return pulse gives one back.
//   clk, rst_n    : clock, async active-low reset
//   clear         : synchronous soft clear (drops the buffered beat)
//   credit_return : remote FIFO freed one entry
//   flags         : credits, empty, stall, overflow
//   push          : upstream stream (sink)
//   pop           : link towards the remote FIFO (source)
module hwpe_stream_credit_tx
  import hwpe_stream_package::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CREDITS    = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        clear,
  input  logic                        credit_return,
  output flags_credit_tx_t            flags,
  hwpe_stream_intf_stream.sink        push,
  hwpe_stream_intf_stream.source      pop
);

  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  credit_tx_state_e state_d, state_q;

  logic [DATA_WIDTH-1:0] data_q;
  logic [STRB_WIDTH-1:0] strb_q;

  logic [7:0] credit_cnt;
  logic       credit_nz;
  logic       credit_ovf;
  logic       out_valid;
  logic       pop_valid;
  logic       push_ready;
  logic       push_hs;
  logic       pop_hs;
  logic       last_credit;
  logic       nz_next;

  hwpe_stream_credit_counter #(
    .CREDITS (CREDITS)
  ) i_counter (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (clear),
    .consume  (pop_hs),
    .give     (credit_return),
    .count    (credit_cnt),
    .nonzero  (credit_nz),
    .overflow (credit_ovf)
  );

  // Illegal encodings read as empty so the link can never present garbage.
  always_comb begin
    out_valid = 1'b0;
    unique case (state_q)
      StHold, StStalled: out_valid = 1'b1;
      default:           out_valid = 1'b0;
    endcase
  end

  assign pop_valid  = out_valid & credit_nz;
  assign push_ready = ~out_valid | (pop_valid & pop.ready);
  assign push_hs    = push.valid & push_ready;
  assign pop_hs     = pop_valid & pop.ready;

  // Whether the counter will be nonzero after this edge (clear handled apart).
  assign last_credit = pop_hs & ~credit_return & (credit_cnt == 8'd1);
  assign nz_next     = credit_return | (credit_nz & ~last_credit);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StEmpty: begin
        if (push_hs) state_d = nz_next ? StHold : StStalled;
      end
      StHold: begin
        if (push_hs) begin
          state_d = nz_next ? StHold : StStalled;
        end else if (pop_hs) begin
          state_d = StEmpty;
        end
      end
      StStalled: begin
        if (credit_return) state_d = StHold;
      end
      default: state_d = StEmpty;
    endcase
    if (clear) state_d = StEmpty;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StEmpty;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      strb_q <= '0;
    end else if (clear) begin
      data_q <= '0;
      strb_q <= '0;
    end else if (push_hs) begin
      data_q <= push.data;
      strb_q <= push.strb;
    end
  end

  assign push.ready = push_ready;
  assign pop.valid  = pop_valid;
  assign pop.data   = data_q;
  assign pop.strb   = strb_q;

  assign flags.credits  = credit_cnt;
  assign flags.empty    = (state_q == StEmpty);
  assign flags.stall    = out_valid & ~credit_nz;
  assign flags.overflow = credit_ovf;

endmodule

// File: tb/tb_hwpe_stream_credit_tx.sv
module tb_hwpe_stream_credit_tx;
  import hwpe_stream_package::*;

  logic clk = 1'b0;
  logic rst_n;
  logic clear;
  logic credit_return;
  flags_credit_tx_t flags;

  hwpe_stream_intf_stream #(.DATA_WIDTH(32)) push_if ();
  hwpe_stream_intf_stream #(.DATA_WIDTH(32)) pop_if ();

  hwpe_stream_credit_tx #(
    .DATA_WIDTH (32),
    .CREDITS    (8)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .clear         (clear),
    .credit_return (credit_return),
    .flags         (flags),
    .push          (push_if),
    .pop           (pop_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        pv;
    logic [31:0] pd;
    logic [3:0]  ps;
    logic        pr;
    logic        cr;
    logic        clr;
    logic        e_pv;
    logic [31:0] e_pd;
    logic [3:0]  e_ps;
    logic        e_prdy;
    logic [7:0]  e_cred;
    logic        e_empty;
    logic        e_stall;
    logic        e_ovf;
  } vec_t;

  vec_t vecs[$];
  int checks = 0;
  int errors = 0;

  function automatic void add(logic pv, logic [31:0] pd, logic [3:0] ps, logic pr, logic cr,
                              logic clr, logic e_pv, logic [31:0] e_pd, logic [3:0] e_ps,
                              logic e_prdy, logic [7:0] e_cred, logic e_empty, logic e_stall,
                              logic e_ovf);
    vec_t v;
    v.pv = pv; v.pd = pd; v.ps = ps; v.pr = pr; v.cr = cr; v.clr = clr;
    v.e_pv = e_pv; v.e_pd = e_pd; v.e_ps = e_ps; v.e_prdy = e_prdy; v.e_cred = e_cred;
    v.e_empty = e_empty; v.e_stall = e_stall; v.e_ovf = e_ovf;
    vecs.push_back(v);
  endfunction

  task automatic chk(string name, int idx, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s [%0d]: got 0x%0h, expected 0x%0h", name, idx, act, exp);
    end
  endtask

  task automatic drive(logic pv, logic [31:0] pd, logic [3:0] ps, logic pr, logic cr,
                       logic clr);
    push_if.valid = pv;
    push_if.data  = pd;
    push_if.strb  = ps;
    pop_if.ready  = pr;
    credit_return = cr;
    clear         = clr;
  endtask

  initial begin
    bit seen;

    rst_n = 1'b0;
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);

    // Reset state
    add(0, 0, 0, 1, 0, 0,  0, 0, 0, 1, 8, 1, 0, 0);
    // Eight beats streamed back to back, ninth one stalls on zero credits
    add(1, 0, 4'hF, 1, 0, 0,  0, 0, 0, 1, 8, 1, 0, 0);
    for (int k = 2; k <= 9; k++)
      add(1, 32'(k - 1), 4'hF, 1, 0, 0,  1, 32'(k - 2), 4'hF, 1, 8'(10 - k), 0, 0, 0);
    add(0, 0, 0, 1, 0, 0,  0, 8, 4'hF, 0, 0, 0, 1, 0);
    // One credit back releases the held beat
    add(0, 0, 0, 1, 1, 0,  0, 8, 4'hF, 0, 0, 0, 1, 0);
    add(0, 0, 0, 1, 0, 0,  1, 8, 4'hF, 1, 1, 0, 0, 0);
    add(0, 0, 0, 1, 0, 0,  0, 8, 4'hF, 1, 0, 1, 0, 0);
    // Return three credits, then pop and return in the same cycle
    for (int i = 0; i < 3; i++)
      add(0, 0, 0, 1, 1, 0,  0, 8, 4'hF, 1, 8'(i), 1, 0, 0);
    add(1, 32'h10, 4'h5, 1, 0, 0,  0, 8, 4'hF, 1, 3, 1, 0, 0);
    add(0, 0, 0, 1, 1, 0,  1, 32'h10, 4'h5, 1, 3, 0, 0, 0);
    add(0, 0, 0, 1, 0, 0,  0, 32'h10, 4'h5, 1, 3, 1, 0, 0);
    // Back-pressure: beat held stable for five cycles
    add(1, 32'hA5A5A5A5, 4'hF, 0, 0, 0,  0, 32'h10, 4'h5, 1, 3, 1, 0, 0);
    for (int i = 0; i < 5; i++)
      add(1, 32'h11, 4'h3, 0, 0, 0,  1, 32'hA5A5A5A5, 4'hF, 0, 3, 0, 0, 0);
    add(0, 0, 0, 1, 0, 0,  1, 32'hA5A5A5A5, 4'hF, 1, 3, 0, 0, 0);
    add(0, 0, 0, 1, 0, 0,  0, 32'hA5A5A5A5, 4'hF, 1, 2, 1, 0, 0);
    // Refill to full, then one extra return overflows
    for (int i = 0; i < 6; i++)
      add(0, 0, 0, 1, 1, 0,  0, 32'hA5A5A5A5, 4'hF, 1, 8'(2 + i), 1, 0, 0);
    add(0, 0, 0, 1, 1, 0,  0, 32'hA5A5A5A5, 4'hF, 1, 8, 1, 0, 0);
    add(1, 32'h22, 4'h1, 0, 0, 0,  0, 32'hA5A5A5A5, 4'hF, 1, 8, 1, 0, 1);
    add(0, 0, 0, 0, 1, 0,  1, 32'h22, 4'h1, 0, 8, 0, 0, 1);
    // Clear drops the held beat and the overflow flag
    add(0, 0, 0, 0, 1, 1,  1, 32'h22, 4'h1, 0, 8, 0, 0, 1);
    add(0, 0, 0, 1, 0, 0,  0, 0, 0, 1, 8, 1, 0, 0);

    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].pv, vecs[i].pd, vecs[i].ps, vecs[i].pr, vecs[i].cr, vecs[i].clr);
      #1;
      chk("pop_valid",  i, 32'(pop_if.valid),   32'(vecs[i].e_pv));
      chk("pop_data",   i, pop_if.data,         vecs[i].e_pd);
      chk("pop_strb",   i, 32'(pop_if.strb),    32'(vecs[i].e_ps));
      chk("push_ready", i, 32'(push_if.ready),  32'(vecs[i].e_prdy));
      chk("credits",    i, 32'(flags.credits),  32'(vecs[i].e_cred));
      chk("empty",      i, 32'(flags.empty),    32'(vecs[i].e_empty));
      chk("stall",      i, 32'(flags.stall),    32'(vecs[i].e_stall));
      chk("overflow",   i, 32'(flags.overflow), 32'(vecs[i].e_ovf));
    end

    // Asynchronous reset while a beat is held
    @(negedge clk);
    drive(1'b1, 32'h33, 4'hC, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);
    #1;
    chk("hold_valid", 100, 32'(pop_if.valid), 32'd1);
    chk("hold_data",  100, pop_if.data, 32'h33);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_valid",   101, 32'(pop_if.valid),   32'd0);
    chk("arst_data",    101, pop_if.data,         32'h0);
    chk("arst_empty",   101, 32'(flags.empty),    32'd1);
    chk("arst_credits", 101, 32'(flags.credits),  32'd8);
    chk("arst_ready",   101, 32'(push_if.ready),  32'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // One-cycle push-to-pop latency, bounded wait
    @(negedge clk);
    drive(1'b1, 32'h44, 4'h9, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    seen = 1'b0;
    for (int c = 0; c < 4 && !seen; c++) begin
      #1;
      if (pop_if.valid === 1'b1) begin
        seen = 1'b1;
        chk("lat_cycles", 102, 32'(c), 32'd0);
        chk("lat_data",   102, pop_if.data, 32'h44);
        chk("lat_strb",   102, 32'(pop_if.strb), 32'h9);
      end else begin
        @(negedge clk);
      end
    end
    chk("lat_seen", 102, 32'(seen), 32'd1);
    @(negedge clk);
    #1;
    chk("lat_credits", 103, 32'(flags.credits), 32'd7);
    chk("lat_empty",   103, 32'(flags.empty),   32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hwpe_stream_credit_tx.md
Name: hwpe_stream_credit_tx

Overview:
- Transmitter-side counterpart of the stream FIFO. Forwards an HWPE-Stream to a remote FIFO only while that FIFO is known to have free space.
- Occupancy is tracked with credits: one credit is consumed per beat sent, and one is returned each time the remote FIFO pops a beat.
- Sits in front of long or registered links where the receiver's `ready` cannot be used combinationally.
- Includes one output register stage.

Parameters:
- DATA_WIDTH, 32: stream data width; STRB_WIDTH = DATA_WIDTH/8.
- CREDITS, 8: initial and maximum credit count. Equals the remote FIFO_DEPTH. Legal range 1..255.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- clear  input  1  synchronous soft clear
- credit_return  input  1  one-cycle pulse; the remote FIFO freed one entry
- flags  output  flags_credit_tx_t  status (credits[7:0], empty, stall, overflow)
- push  hwpe_stream_intf_stream.sink  DATA_WIDTH  upstream stream
- pop  hwpe_stream_intf_stream.source  DATA_WIDTH  link towards the remote FIFO

Behaviour:
- Reset (rst_n=0, asynchronous):
  - credit_cnt=CREDITS, out_valid=0, out data/strb='0, overflow=0.
  - Outputs: pop.valid=0, push.ready=1, flags.credits=CREDITS, flags.empty=1, flags.stall=0, flags.overflow=0.
- clear=1 (synchronous): same state as reset at the next edge. The buffered beat is dropped. A credit_return in the same cycle is ignored.
- Output register (one entry):
  - out_valid: set on a push handshake, cleared on a pop handshake without a simultaneous push.
  - Data and strb are captured on the push handshake.
- Handshakes:
  - pop.valid = out_valid & (credit_cnt != 0).
  - push.ready = ~out_valid | (pop.valid & pop.ready). Full throughput of 1 beat/cycle while credits last.
  - Latency push→pop: 1 cycle.
  - pop.data/strb must stay stable while pop.valid=1 and pop.ready=0.
  - With out_valid=1 and credit_cnt=0, the beat is held and pop.valid=0.
  - pop.valid never deasserts without a handshake, except via clear or reset.
- Credit counter (8 bit, unsigned):
  - Pop handshake only: cnt−1.
  - credit_return only: cnt+1.
  - Both in the same cycle: unchanged.
  - Neither: unchanged.
- Boundary conditions:
  - cnt=0: a credit_return raises cnt to 1, and pop.valid may assert in the next cycle.
  - cnt=0 with a pending beat: flags.stall=1 (out_valid & cnt==0).
  - credit_return with cnt==CREDITS and no pop handshake: the counter saturates at CREDITS. flags.overflow is set and stays sticky until clear or reset.
  - cnt decrement below 0 is impossible by construction. Verification asserts it.
- FSM (2 bits):
  - States: EMPTY (out_valid=0), HOLD (out_valid=1, cnt>0), STALLED (out_valid=1, cnt=0).
  - EMPTY→HOLD/STALLED on push.
  - HOLD→EMPTY on pop without push; HOLD→STALLED when the last credit is used while a new beat is pushed.
  - STALLED→HOLD on credit_return.
  - Undefined encoding → EMPTY.
- flags.empty = (state==EMPTY). flags.credits = credit_cnt.

Decomposition:
- In hwpe_stream_package:
  - typedef flags_credit_tx_t {logic [7:0] credits; logic empty; logic stall; logic overflow;}.
  - Constant HWPE_STREAM_CREDIT_MAX=255.
- One sub-module: hwpe_stream_credit_counter.
  - Parameter CREDITS; inputs clk, rst_n, clear, consume, give.
  - Outputs count[7:0], nonzero, overflow.
  - Reusable on the receiver side to generate credit_return.

Test Plan:
1. Reset with CREDITS=8 → pop.valid=0, push.ready=1, flags.credits=8, empty=1, stall=0, overflow=0.
2. Push 8 beats 0x00..0x07 with pop.ready=1 and no returns → beats appear 1 cycle after push, in order. After the 8th, credits=0. A 9th beat 0x08 is held with stall=1 and push.ready=0.
3. From test 2, pulse credit_return once → next cycle pop.valid=1 and 0x08 transfers; credits ends at 0; stall=0 after the transfer.
4. Pop handshake and credit_return in the same cycle with credits=3 → credits stays 3.
5. pop.ready=0 for 5 cycles with beat 0xA5A5A5A5 / strb 0xF held → pop.data and strb are stable and push.ready=0. On pop.ready=1 → single transfer.
6. credit_return at credits=8 → credits stays 8, overflow=1. Assert clear → credits=8, overflow=0, empty=1, and the held beat is discarded.
